// File: rtl/gardner_ted.sv
// rtl/gardner_ted.sv - Gardner timing-error detector with raw I/Q delay tap
module gardner_ted #(
   parameter int OSF     = 20,
   parameter int WI      = 16,
   parameter int WO      = 18,
   parameter int RAW_DLY = 10
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic signed [WI-1:0] i_in,
   input  logic signed [WI-1:0] q_in,
   input  logic                 iq_val,
   input  logic                 sym_valid_i,
   output logic signed [WO-1:0] e_out_o,
   output logic                 e_valid_o,
   output logic signed [WI-1:0] i_raw_delay_o,
   output logic signed [WI-1:0] q_raw_delay_o
);

   localparam int CW = $clog2(OSF + 2);
   localparam logic [CW-1:0] FULL = CW'(OSF + 1);
   localparam int WP = 2 * WI + 1;
   localparam int WS = 2 * WI + 2;
   localparam int SH = WS - WO;
   // Saturation bounds of the WO-bit result, expressed at full sum width
   localparam logic signed [WS-1:0] E_MAX = {{(WS - WO + 1){1'b0}}, {(WO - 1){1'b1}}};
   localparam logic signed [WS-1:0] E_MIN = {{(WS - WO + 1){1'b1}}, {(WO - 1){1'b0}}};

   logic signed [WI-1:0] xi [0:OSF];
   logic signed [WI-1:0] xq [0:OSF];
   logic [CW-1:0]        fill_cnt;
   logic                 armed;
   logic                 capture;

   logic signed [WI:0]   d_i, d_q;
   logic signed [WI-1:0] mid_i, mid_q;
   logic                 v1;
   logic signed [WP-1:0] p_i, p_q;
   logic                 v2;
   logic signed [WS-1:0] s_sum, s_shift;
   logic signed [WO-1:0] e_sat;

   assign armed   = (fill_cnt == FULL);
   assign capture = sym_valid_i && armed;

   assign i_raw_delay_o = xi[RAW_DLY];
   assign q_raw_delay_o = xq[RAW_DLY];

   // Sample delay line: shifts only on valid input samples, x[0] newest
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int k = 0; k <= OSF; k++) begin
            xi[k] <= '0;
            xq[k] <= '0;
         end
      end else if (iq_val) begin
         xi[0] <= i_in;
         xq[0] <= q_in;
         for (int k = 1; k <= OSF; k++) begin
            xi[k] <= xi[k-1];
            xq[k] <= xq[k-1];
         end
      end
   end

   // Fill counter: arms the detector once the whole line holds real samples
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fill_cnt <= '0;
      end else if (iq_val && !armed) begin
         fill_cnt <= fill_cnt + 1'b1;
      end
   end

   // Stage 1: capture taps as they stand before any same-cycle shift
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         v1    <= 1'b0;
         d_i   <= '0;
         d_q   <= '0;
         mid_i <= '0;
         mid_q <= '0;
      end else begin
         v1 <= capture;
         if (capture) begin
            d_i   <= {xi[OSF][WI-1], xi[OSF]} - {xi[0][WI-1], xi[0]};
            d_q   <= {xq[OSF][WI-1], xq[OSF]} - {xq[0][WI-1], xq[0]};
            mid_i <= xi[OSF/2];
            mid_q <= xq[OSF/2];
         end
      end
   end

   // Stage 2: per-rail products mid * (prev - cur)
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         v2  <= 1'b0;
         p_i <= '0;
         p_q <= '0;
      end else begin
         v2 <= v1;
         if (v1) begin
            p_i <= WP'(mid_i) * WP'(d_i);
            p_q <= WP'(mid_q) * WP'(d_q);
         end
      end
   end

   // Rail sum, floor scaling by arithmetic shift, clamp to output range
   always_comb begin
      s_sum   = {p_i[WP-1], p_i} + {p_q[WP-1], p_q};
      s_shift = s_sum >>> SH;
      e_sat   = s_shift[WO-1:0];
      if (s_shift > E_MAX) begin
         e_sat = E_MAX[WO-1:0];
      end else if (s_shift < E_MIN) begin
         e_sat = E_MIN[WO-1:0];
      end
   end

   // Stage 3: registered error and its one-cycle valid pulse
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         e_valid_o <= 1'b0;
         e_out_o   <= '0;
      end else begin
         e_valid_o <= v2;
         if (v2) begin
            e_out_o <= e_sat;
         end
      end
   end

endmodule

// File: tb/tb_gardner_ted.sv
// tb/tb_gardner_ted.sv - self-checking bench for gardner_ted
module tb_gardner_ted;

   localparam int OSF     = 20;
   localparam int WI      = 16;
   localparam int WO      = 18;
   localparam int RAW_DLY = 10;
   localparam int SH      = 2 * WI + 2 - WO;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic signed [WI-1:0] i_in, q_in;
   logic                 iq_val, sym_valid_i;
   logic signed [WO-1:0] e_out_o;
   logic                 e_valid_o;
   logic signed [WI-1:0] i_raw_delay_o, q_raw_delay_o;

   gardner_ted #(.OSF(OSF), .WI(WI), .WO(WO), .RAW_DLY(RAW_DLY)) dut (
      .clk(clk), .reset_n(reset_n), .i_in(i_in), .q_in(q_in),
      .iq_val(iq_val), .sym_valid_i(sym_valid_i),
      .e_out_o(e_out_o), .e_valid_o(e_valid_o),
      .i_raw_delay_o(i_raw_delay_o), .q_raw_delay_o(q_raw_delay_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   longint cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      longint e;
      longint at;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      int pi, mi, ci, pq, mq, cq;
      longint e;
   } vec_t;
   vec_t tbl[6];

   int mi_t[0:OSF];
   int mq_t[0:OSF];
   int m_cnt;

   task automatic chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic longint ted_model();
      longint s;
      s = longint'(mi_t[OSF/2]) * longint'(mi_t[OSF] - mi_t[0])
        + longint'(mq_t[OSF/2]) * longint'(mq_t[OSF] - mq_t[0]);
      s = s >>> SH;
      if (s > (64'sd1 <<< (WO - 1)) - 1) s = (64'sd1 <<< (WO - 1)) - 1;
      if (s < -(64'sd1 <<< (WO - 1)))    s = -(64'sd1 <<< (WO - 1));
      return s;
   endfunction

   // Scoreboard consumer: every error pulse must match the oldest expectation
   always @(negedge clk) begin
      if (e_valid_o) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_e_valid: got e_out %0d with no strobe pending (cycle %0d)", e_out_o, cyc);
         end else begin
            exp_t x;
            x = sbq.pop_front();
            chk("e_out", longint'(e_out_o), x.e);
            chk("e_latency", cyc, x.at);
         end
      end
   end

   task automatic step(bit v, int si, int sq, bit s, bit ovr = 1'b0, longint oe = 0);
      exp_t x;
      iq_val      = v;
      i_in        = WI'(si);
      q_in        = WI'(sq);
      sym_valid_i = s;
      if (s && m_cnt >= OSF + 1) begin
         x.e  = ovr ? oe : ted_model();
         x.at = cyc + 3;
         sbq.push_back(x);
      end
      if (v) begin
         for (int k = OSF; k > 0; k--) begin
            mi_t[k] = mi_t[k-1];
            mq_t[k] = mq_t[k-1];
         end
         mi_t[0] = si;
         mq_t[0] = sq;
         if (m_cnt < OSF + 1) m_cnt++;
      end
      @(posedge clk);
      @(negedge clk);
      chk("i_raw", longint'(i_raw_delay_o), longint'(mi_t[RAW_DLY]));
      chk("q_raw", longint'(q_raw_delay_o), longint'(mq_t[RAW_DLY]));
      iq_val      = 1'b0;
      sym_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n     = 1'b0;
      iq_val      = 1'b0;
      sym_valid_i = 1'b0;
      i_in        = '0;
      q_in        = '0;
      @(posedge clk);
      sbq.delete();
      for (int k = 0; k <= OSF; k++) begin
         mi_t[k] = 0;
         mq_t[k] = 0;
      end
      m_cnt = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_e_out", longint'(e_out_o), 0);
      chk("rst_e_valid", longint'(e_valid_o), 0);
      chk("rst_i_raw", longint'(i_raw_delay_o), 0);
      chk("rst_q_raw", longint'(q_raw_delay_o), 0);
      reset_n = 1'b1;
   endtask

   // Load prev at x[OSF], mid at x[OSF/2], cur at x[0], zeros elsewhere
   task automatic load_vec(vec_t t);
      for (int j = 0; j <= OSF; j++) begin
         if (j == 0)            step(1'b1, t.pi, t.pq, 1'b0);
         else if (j == OSF / 2) step(1'b1, t.mi, t.mq, 1'b0);
         else if (j == OSF)     step(1'b1, t.ci, t.cq, 1'b0);
         else                   step(1'b1, 0, 0, 1'b0);
      end
   endtask

   initial begin
      tbl[0] = '{pi: 1000,  mi: 100,    ci: -1000,  pq: 0,     mq: 0,      cq: 0,      e: 3};
      tbl[1] = '{pi: 0,     mi: 0,      ci: 0,      pq: -1000, mq: 100,    cq: 1000,   e: -4};
      tbl[2] = '{pi: 1000,  mi: 100,    ci: -1000,  pq: 1000,  mq: 100,    cq: -1000,  e: 6};
      tbl[3] = '{pi: 32767, mi: -32768, ci: -32768, pq: 32767, mq: -32768, cq: -32768, e: -65535};
      tbl[4] = '{pi: 7,     mi: 9000,   ci: 7,      pq: -3,    mq: -9000,  cq: -3,     e: 0};
      tbl[5] = '{pi: -1000, mi: 100,    ci: 1000,   pq: 0,     mq: 0,      cq: 0,      e: -4};

      reset_n = 1'b0; iq_val = 1'b0; sym_valid_i = 1'b0; i_in = '0; q_in = '0;
      do_reset();

      // Warm-up: 20 samples with a strobe after each must never fire
      for (int j = 0; j < OSF; j++) begin
         step(1'b1, 0, 0, 1'b0);
         step(1'b0, 0, 0, 1'b1);
      end
      chk("warmup_e_out", longint'(e_out_o), 0);

      // Table vectors with known errors
      foreach (tbl[n]) begin
         load_vec(tbl[n]);
         step(1'b0, 0, 0, 1'b1, 1'b1, tbl[n].e);
         repeat (3) step(1'b0, 0, 0, 1'b0);
      end

      // Back-to-back strobes with shifting in the same cycles
      load_vec(tbl[2]);
      for (int j = 0; j < 4; j++) step(1'b1, 3000 * j - 4000, 2500 - 1700 * j, 1'b1);
      repeat (4) step(1'b0, 0, 0, 1'b0);

      // Constant input: every error is zero
      for (int j = 0; j <= OSF; j++) step(1'b1, 5000, 5000, 1'b0);
      for (int n = 0; n < 4; n++)
         for (int j = 0; j < OSF; j++)
            step(1'b1, 5000, 5000, j == OSF - 1, 1'b1, 0);
      repeat (4) step(1'b0, 0, 0, 1'b0);

      // Random traffic with gaps and random strobes
      for (int j = 0; j < 300; j++) begin
         logic signed [WI-1:0] ri, rq;
         ri = WI'($urandom);
         rq = WI'($urandom);
         step($urandom_range(0, 3) != 0, int'(ri), int'(rq), $urandom_range(0, 4) == 0);
      end
      repeat (4) step(1'b0, 0, 0, 1'b0);

      // Raw impulse with iq_val deasserted every other cycle
      do_reset();
      for (int j = 0; j < 5; j++) begin
         step(1'b1, 0, 0, 1'b0);
         step(1'b0, 0, 0, 1'b0);
      end
      step(1'b1, 1234, 0, 1'b0);
      for (int n = 1; n <= 11; n++) begin
         step(1'b0, 0, 0, 1'b0);
         step(1'b1, 0, 0, 1'b0);
         chk("impulse_i", longint'(i_raw_delay_o), (n == RAW_DLY) ? 1234 : 0);
         chk("impulse_q", longint'(q_raw_delay_o), 0);
      end

      // Reset with an error in flight, then re-arm only after OSF+1 samples
      load_vec(tbl[0]);
      step(1'b0, 0, 0, 1'b1, 1'b1, 3);
      step(1'b0, 0, 0, 1'b0);
      do_reset();
      for (int j = 0; j < OSF; j++) step(1'b1, 1111, -2222, 1'b1);
      load_vec(tbl[3]);
      step(1'b0, 0, 0, 1'b1, 1'b1, -65535);
      repeat (5) step(1'b0, 0, 0, 1'b0);

      chk("scoreboard_drained", longint'(sbq.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
